pulse_driver: RTL

PULSE_DRIVER -- requirements
Module: pulse_driver

---
 rtl/pulse_driver_pkg.sv | 14 +
 rtl/pd_down_counter.sv | 25 ++
 rtl/pulse_driver.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pulse_driver_pkg.sv
// Shared types and default timing constants for the pulse driver.
package pulse_driver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam int unsigned DEF_HOLD_CYCLES = 8;
  localparam int unsigned DEF_GAP_CYCLES  = 4;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/pd_down_counter.sv
// Loadable down counter with zero flag; times both the ACTIVE and GAP phases.
module pd_down_counter
  import pulse_driver_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n)                cnt_q <= '0;
    else if (load_i)             cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_driver.sv
// Triggered fixed-width pulse generator with forced-low recovery gap.
// Optional one-deep request queue: define PULSE_DRIVER_PENDING_EN.
module pulse_driver
  import pulse_driver_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trigger,
  input  logic cancel,
  output logic drive,
  output logic busy,
  output logic done,
  output logic dropped
);

  localparam logic [CNT_W-1:0] HOLD_LV = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LV  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t state_q, state_d;
  logic   drive_q, busy_q, done_q, dropped_q;
  logic   done_d, dropped_d;
  logic   start_active, start_gap, cnt_dec, cnt_zero;
  logic   trig_ok, pend_q;

  // cancel beats a simultaneous trigger everywhere
  assign trig_ok = trigger & ~cancel;

`ifdef PULSE_DRIVER_PENDING_EN
  logic pend_d;

  always_comb begin
    pend_d = pend_q;
    if (cancel || start_active)
      pend_d = 1'b0;
    else if (state_q != IDLE && trigger && !pend_q)
      pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) pend_q <= 1'b0;
    else          pend_q <= pend_d;
  end

  // a request with the slot already full is lost; in IDLE the slot is
  // consumed by the start, so the concurrent trigger is the overflow
  assign dropped_d = trig_ok & pend_q;
`else
  assign pend_q    = 1'b0;
  assign dropped_d = trig_ok & (state_q != IDLE);
`endif

  always_comb begin
    state_d      = state_q;
    start_active = 1'b0;
    start_gap    = 1'b0;
    cnt_dec      = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_ok || (pend_q && !cancel)) start_active = 1'b1;
      end
      ACTIVE: begin
        if (cancel) begin
          if (GAP_CYCLES != 0) start_gap = 1'b1;
          else                 state_d   = IDLE;
        end else if (cnt_zero) begin
          done_d = 1'b1;
          if (GAP_CYCLES != 0) start_gap    = 1'b1;
          else if (pend_q)     start_active = 1'b1;
          else                 state_d      = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          if (pend_q && !cancel) start_active = 1'b1;
          else                   state_d      = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_active) state_d = ACTIVE;
    if (start_gap)    state_d = GAP;
  end

  pd_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (start_active | start_gap),
    .load_val_i (start_gap ? GAP_LV : HOLD_LV),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      drive_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drive_q   <= (state_d == ACTIVE);
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
      dropped_q <= dropped_d;
    end
  end

  assign drive   = drive_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign dropped = dropped_q;

endmodule
